psram_pll_sequencer: RTL and testbench

Sequences the PSRAM clock rPLL (27 MHz in, 158.625 MHz out) from the always-running 27 MHz input clock. Drives the PLL RESET/RESET_P pins and samples the asynchronous LOCK. Holds the PSRAM controller in reset until lock has been stable, and recovers automatically from lock loss or lock timeout. Owns the dynamic phase (PSDA) and duty (DUTYDA) inputs and applies run-time phase changes through a req/ack handshake, with a settle window, for PSRAM read-capture calibration.

---
 rtl/psram_pll_pkg.sv | 13 +
 rtl/sync_2ff.sv | 15 +
 rtl/psram_pll_sequencer.sv | 97 +++++++++
 tb/tb_psram_pll_sequencer.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/psram_pll_pkg.sv
// psram_pll_pkg: shared state encoding and default timing for the PSRAM PLL sequencer.
package psram_pll_pkg;

   typedef enum logic [2:0] {PLL_RST, WAIT_LOCK, STABLE, RUN, PHASE} state_t;

   localparam int DEF_RST_CYCLES    = 16;
   localparam int DEF_LOCK_TIMEOUT  = 65536;
   localparam int DEF_STABLE_CYCLES = 1024;
   localparam int DEF_SETTLE_CYCLES = 64;
   localparam int DEF_CNT_W         = 17;
   localparam int PS_W              = 4;

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for a single asynchronous bit.
module sync_2ff (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk)
      if (rst) {meta, q} <= 2'b00;
      else     {meta, q} <= {d, meta};

endmodule

// File: rtl/psram_pll_sequencer.sv
// psram_pll_sequencer: rPLL reset/lock sequencing, PSRAM reset release and dynamic phase stepping.
module psram_pll_sequencer
   import psram_pll_pkg::*;
#(
   parameter int              RST_CYCLES    = DEF_RST_CYCLES,
   parameter int              LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
   parameter int              STABLE_CYCLES = DEF_STABLE_CYCLES,
   parameter int              SETTLE_CYCLES = DEF_SETTLE_CYCLES,
   parameter int              CNT_W         = DEF_CNT_W,
   parameter logic [PS_W-1:0] PSDA_INIT     = 4'b0000,
   parameter logic [PS_W-1:0] DUTYDA_INIT   = 4'b1000
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            pll_lock,
   output logic            pll_reset,
   output logic            pll_reset_p,
   output logic [PS_W-1:0] pll_psda,
   output logic [PS_W-1:0] pll_dutyda,
   output logic            psram_rst,
   output logic            ready,
   input  logic            phase_req,
   input  logic [PS_W-1:0] phase_val,
   output logic            phase_ack,
   output logic [7:0]      relock_cnt
);

   localparam logic [CNT_W-1:0] RST_LD = CNT_W'(RST_CYCLES - 1);
   localparam logic [CNT_W-1:0] TO_LD  = CNT_W'(LOCK_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] ST_LD  = CNT_W'(STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] SET_LD = CNT_W'(SETTLE_CYCLES - 1);

   state_t            state, state_nx;
   logic [CNT_W-1:0]  cnt, cnt_nx;
   logic              lock_s, expired, run_now, run_nx, bump;
   logic              pll_reset_d, psram_rst_d, ready_d, phase_ack_d;
   logic [PS_W-1:0]   psda_d;
   logic [7:0]        relock_d;

   sync_2ff u_lock_sync (.clk(clk), .rst(rst), .d(pll_lock), .q(lock_s));

   assign expired     = cnt == '0;
   assign pll_reset_p = pll_reset;
   assign pll_dutyda  = DUTYDA_INIT;

   always_ff @(posedge clk)
      if (rst) begin
         state      <= PLL_RST;
         cnt        <= RST_LD;
         pll_reset  <= 1'b1;
         psram_rst  <= 1'b1;
         ready      <= 1'b0;
         phase_ack  <= 1'b0;
         pll_psda   <= PSDA_INIT;
         relock_cnt <= '0;
      end else begin
         state      <= state_nx;
         cnt        <= cnt_nx;
         pll_reset  <= pll_reset_d;
         psram_rst  <= psram_rst_d;
         ready      <= ready_d;
         phase_ack  <= phase_ack_d;
         pll_psda   <= psda_d;
         relock_cnt <= relock_d;
      end

   always_comb begin
      state_nx = state;
      cnt_nx   = expired ? cnt : cnt - 1'b1;
      case (state)
         PLL_RST:   if (expired) begin state_nx = WAIT_LOCK; cnt_nx = TO_LD; end
         WAIT_LOCK: if (lock_s) begin state_nx = STABLE; cnt_nx = ST_LD; end
                    else if (expired) begin state_nx = PLL_RST; cnt_nx = RST_LD; end
         STABLE:    if (!lock_s) begin state_nx = WAIT_LOCK; cnt_nx = TO_LD; end
                    else if (expired) state_nx = RUN;
         RUN:       if (!lock_s) begin state_nx = PLL_RST; cnt_nx = RST_LD; end
                    else if (phase_req) begin state_nx = PHASE; cnt_nx = SET_LD; end
         PHASE:     if (!lock_s) begin state_nx = PLL_RST; cnt_nx = RST_LD; end
                    else if (expired) state_nx = RUN;
         default:   begin state_nx = PLL_RST; cnt_nx = RST_LD; end
      endcase
   end

   // Outputs are registered from the transition, so release and ready need a full cycle in RUN.
   always_comb begin
      run_now     = state == RUN || state == PHASE;
      run_nx      = state_nx == RUN || state_nx == PHASE;
      bump        = state_nx == PLL_RST && state != PLL_RST;
      pll_reset_d = state_nx == PLL_RST;
      psram_rst_d = !(run_now && run_nx);
      ready_d     = state == RUN && state_nx == RUN;
      phase_ack_d = state == PHASE && state_nx == RUN;
      psda_d      = (state == RUN && state_nx == PHASE) ? phase_val : pll_psda;
      relock_d    = (bump && relock_cnt != 8'hff) ? relock_cnt + 8'd1 : relock_cnt;
   end

endmodule

// File: tb/tb_psram_pll_sequencer.sv
// tb_psram_pll_sequencer: scoreboard bench; every output change is matched against a queued expectation.
module tb_psram_pll_sequencer;

   typedef struct {
      string       name;
      int          cyc;
      logic [15:0] v;
   } exp_t;

   logic       clk, rst, pll_lock, phase_req;
   logic [3:0] phase_val, pll_psda, pll_dutyda;
   logic       pll_reset, pll_reset_p, psram_rst, ready, phase_ack;
   logic [7:0] relock_cnt;

   exp_t        q[$];
   int          cyc = 0;
   int          checks = 0;
   int          fails = 0;
   logic        mon_en = 1'b0;
   logic        probe = 1'b0;
   logic [15:0] prev = 16'hC000;

   psram_pll_sequencer #(.LOCK_TIMEOUT(100)) dut (
      .clk(clk), .rst(rst), .pll_lock(pll_lock),
      .pll_reset(pll_reset), .pll_reset_p(pll_reset_p),
      .pll_psda(pll_psda), .pll_dutyda(pll_dutyda),
      .psram_rst(psram_rst), .ready(ready),
      .phase_req(phase_req), .phase_val(phase_val),
      .phase_ack(phase_ack), .relock_cnt(relock_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // flags = {pll_reset, psram_rst, ready, phase_ack}
   function automatic void push(string n, int c, logic [3:0] flags, logic [3:0] psda, logic [7:0] rc);
      q.push_back('{n, c, {flags, psda, rc}});
   endfunction

   function automatic logic [7:0] sat(int v);
      return v > 255 ? 8'd255 : 8'(v);
   endfunction

   task automatic goto(int n);
      while (cyc < n) begin
         @(posedge clk);
         #2;
      end
   endtask

   always @(negedge clk) begin
      logic [15:0] snap;
      exp_t        e;
      if (mon_en) begin
         snap = {pll_reset, psram_rst, ready, phase_ack, pll_psda, relock_cnt};
         if (snap != prev || phase_ack || probe) begin
            checks++;
            if (q.size() == 0) begin
               fails++;
               $display("FAIL unexpected_event: cyc=%0d got=%h, required no change", cyc, snap);
            end else begin
               e = q.pop_front();
               if (snap != e.v || (e.cyc >= 0 && e.cyc != cyc) || pll_reset_p != e.v[15] || pll_dutyda != 4'h8) begin
                  fails++;
                  $display("FAIL %s: cyc=%0d got=%h reset_p=%b dutyda=%h, required cyc=%0d val=%h reset_p=%b dutyda=8",
                           e.name, cyc, snap, pll_reset_p, pll_dutyda, e.cyc, e.v, e.v[15]);
               end
            end
         end
         prev = snap;
      end
   end

   initial begin
      int t0, t1, t2, t3, p0, n;
      rst = 1'b1; pll_lock = 1'b1; phase_req = 1'b0; phase_val = 4'h0;
      repeat (2) @(posedge clk);
      #2;
      mon_en = 1'b1;
      push("reset_state", -1, 4'b1100, 4'h0, 8'd0);
      probe = 1'b1;
      @(posedge clk);
      #2;
      probe = 1'b0;
      rst = 1'b0;
      t0 = cyc;
      push("pll_reset_release", t0 + 16, 4'b0100, 4'h0, 8'd0);
      push("ready_after_lock", t0 + 1042, 4'b0010, 4'h0, 8'd0);
      goto(t0 + 1045);
      t1 = cyc;
      phase_req = 1'b1; phase_val = 4'h5;
      push("phase_start", t1 + 1, 4'b0000, 4'h5, 8'd0);
      push("phase_ack", t1 + 65, 4'b0001, 4'h5, 8'd0);
      push("ready_after_ack", t1 + 66, 4'b0010, 4'h5, 8'd0);
      n = 0;
      while (!phase_ack && n < 100) begin
         @(posedge clk);
         #2;
         n++;
      end
      checks++;
      if (!phase_ack) begin
         fails++;
         $display("FAIL ack_wait: got no phase_ack in %0d cycles, required one", n);
      end
      phase_req = 1'b0;
      goto(t1 + 70);
      t2 = cyc;
      phase_req = 1'b1; phase_val = 4'hC;
      push("phase2_start", t2 + 1, 4'b0000, 4'hC, 8'd0);
      @(posedge clk);
      #2;
      phase_req = 1'b0;
      goto(t2 + 10);
      pll_lock = 1'b0;
      p0 = t2 + 13;
      push("lock_loss_in_phase", p0, 4'b1100, 4'hC, 8'd1);
      for (int k = 0; k < 256; k++) begin
         push("timeout_release", p0 + 116 * k + 16, 4'b0100, 4'hC, sat(1 + k));
         push("timeout_retry", p0 + 116 * (k + 1), 4'b1100, 4'hC, sat(2 + k));
      end
      goto(p0 + 116 * 256 + 3);
      rst = 1'b1;
      push("rst_clears_relock", p0 + 116 * 256 + 4, 4'b1100, 4'h0, 8'd0);
      pll_lock = 1'b1;
      repeat (3) @(posedge clk);
      #2;
      rst = 1'b0;
      t3 = cyc;
      push("glitch_pll_reset_release", t3 + 16, 4'b0100, 4'h0, 8'd0);
      push("glitch_ready", t3 + 1531, 4'b0010, 4'h0, 8'd0);
      goto(t3 + 500);
      pll_lock = 1'b0;
      goto(t3 + 503);
      pll_lock = 1'b1;
      goto(t3 + 1540);
      phase_req = 1'b1; phase_val = 4'h3;
      push("phase3_start", t3 + 1541, 4'b0000, 4'h3, 8'd0);
      goto(t3 + 1550);
      rst = 1'b1; phase_req = 1'b0;
      push("rst_in_phase", t3 + 1551, 4'b1100, 4'h0, 8'd0);
      goto(t3 + 1560);
      checks++;
      if (q.size() != 0) begin
         fails++;
         $display("FAIL pending_events: got %0d unseen, required 0 (next %s)", q.size(), q[0].name);
      end
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
